wvfm_loader: RTL and testbench
==============================

WVFM_LOADER -- requirements
Module: wvfm_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning number of payload bytes written per load.
REQ-002 SHALL have parameter ABITS, default 12, meaning LUT write-address width, with DEPTH <= 2^ABITS.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle load request.
REQ-006 SHALL have port abort  input  1  single-cycle cancel request.
REQ-007 SHALL have port s_data  input  8  byte-stream data.
REQ-008 SHALL have port s_valid  input  1  byte-stream valid.
REQ-009 SHALL have port s_ready  output  1  byte-stream ready.
REQ-010 SHALL have port lut_we  output  1  waveform LUT write enable.
REQ-011 SHALL have port lut_addr  output  ABITS  waveform LUT byte address.
REQ-012 SHALL have port lut_din  output  8  waveform LUT write data.
REQ-013 SHALL have port busy  output  1  load in progress; consumers must not scan the LUT while it is high.
REQ-014 SHALL have port done  output  1  single-cycle pulse on successful completion.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement a state machine with states IDLE, LOAD and CSUM.
REQ-017 SHALL define a byte as accepted in a cycle where s_valid && s_ready.
REQ-018 IDLE: s_ready=0 and busy=0; start -> LOAD, with address counter := 0, running sum := 0 and err := 0.
REQ-019 LOAD: s_ready=1 and busy=1; each accepted byte adds to an 8-bit sum (mod 256) and increments the address counter.
REQ-020 LOAD: when the byte at address DEPTH-1 is accepted, the next state SHALL be CSUM; the counter SHALL NOT wrap past DEPTH-1.
REQ-021 CSUM: s_ready=1 and busy=1; the next accepted byte SHALL be the checksum, which is not written to the LUT.
REQ-022 CSUM: on checksum acceptance, -> IDLE with done=1 for exactly one cycle; err := 1 if checksum != running sum, otherwise err stays 0.
REQ-023 done SHALL pulse on both a checksum match and a mismatch; err distinguishes the two outcomes.
REQ-024 Write timing: a byte accepted at address A in cycle N SHALL give, in cycle N+1, lut_we=1, lut_addr=A and lut_din=byte; otherwise lut_we=0.
REQ-025 lut_addr and lut_din SHALL hold their last values when lut_we=0.
REQ-026 s_valid low in LOAD or CSUM SHALL stall with no timeout; state, counter and sum are held.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 abort while busy=1 SHALL give: -> IDLE next cycle, err := 1, no done, and no further LUT writes; a byte presented in the same cycle SHALL NOT be accepted.
REQ-029 s_ready SHALL be 0 in the cycle abort is high, so that REQ-028 holds.
REQ-030 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL start a load.
REQ-031 The lut_we pulse for the last payload byte SHALL still occur in the cycle after the LOAD -> CSUM transition.
REQ-032 done SHALL be asserted in the cycle after checksum acceptance, with busy=0 in that same cycle.
REQ-033 err SHALL remain set until the next accepted start or rst.

Reset
REQ-034 rst SHALL force state=IDLE, s_ready=0, lut_we=0, lut_addr=0, lut_din=0, busy=0, done=0, err=0, address counter=0 and sum=0.
REQ-035 rst mid-load SHALL abandon the load without an err indication; any partially written LUT contents remain.
REQ-036 rst SHALL take priority over start, abort and stream input in the same cycle.

Verification
REQ-037 DEPTH=8; start, then bytes 01..08 back-to-back, then checksum 0x24 -> 8 lut_we pulses at addresses 0..7 with data 01..08, each one cycle after acceptance; done pulses once; err=0.
REQ-038 Same load with checksum 0x25 -> all 8 writes occur, done pulses once, err=1 and held until the next start.
REQ-039 s_valid toggling 1,0,0,1 during LOAD -> writes only for accepted bytes; addresses stay contiguous; no duplicate writes.
REQ-040 abort after 3 bytes, with s_valid=1 in the abort cycle -> exactly 3 writes (addresses 0..2); busy=0 next cycle; err=1; done never asserts.
REQ-041 start pulsed again mid-load, then rst asserted mid-load -> the mid-load start has no effect; rst gives all outputs 0 the next cycle; a following start runs a clean load from address 0.
REQ-042 DEPTH=4096 with payload all 0xFF -> checksum 0x00 accepted; last write at address 4095; no write at address 0 after wrap.

Source files
------------

// File: rtl/wvfm_loader.sv
// wvfm_loader: streams DEPTH payload bytes into a waveform LUT,
// then checks a trailing 8-bit additive checksum.
module wvfm_loader #(
   parameter int DEPTH = 4096,
   parameter int ABITS = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             lut_we,
   output logic [ABITS-1:0] lut_addr,
   output logic [7:0]       lut_din,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CSUM
   } state_t;

   state_t           state_q, state_d;
   logic [ABITS-1:0] addr_q, addr_d;
   logic [7:0]       sum_q, sum_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic             we_q, we_d;
   logic [ABITS-1:0] waddr_q, waddr_d;
   logic [7:0]       wdin_q, wdin_d;

   logic accept;
   logic last;

   // Abort blocks acceptance in its own cycle so no byte slips through.
   assign busy    = (state_q != IDLE);
   assign s_ready = busy && !abort;
   assign accept  = s_valid && s_ready;
   assign last    = (addr_q == ABITS'(DEPTH - 1));

   assign lut_we   = we_q;
   assign lut_addr = waddr_q;
   assign lut_din  = wdin_q;
   assign done     = done_q;
   assign err      = err_q;

   // Next-state: load sequencing, checksum compare and write staging.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      err_d   = err_q;
      done_d  = 1'b0;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdin_d  = wdin_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               addr_d  = '0;
               sum_d   = '0;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (accept) begin
               we_d    = 1'b1;
               waddr_d = addr_q;
               wdin_d  = s_data;
               sum_d   = sum_q + s_data;
               if (last) begin
                  state_d = CSUM;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         CSUM: begin
            if (abort) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (accept) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = (s_data != sum_q);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdin_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         done_q  <= done_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdin_q  <= wdin_d;
      end
   end

endmodule

// File: tb/tb_wvfm_loader.sv
// tb_wvfm_loader: scoreboard bench for wvfm_loader with a DEPTH=8
// instance for protocol scenarios and a DEPTH=4096 instance for wrap.
module tb_wvfm_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, s_valid;
   logic [7:0] s_data;
   logic       s_ready, lut_we, busy, done, err;
   logic [2:0] lut_addr;
   logic [7:0] lut_din;

   logic        b_rst, b_start, b_abort, b_valid;
   logic [7:0]  b_data;
   logic        b_ready, b_we, b_busy, b_done, b_err;
   logic [11:0] b_addr;
   logic [7:0]  b_din;

   wvfm_loader #(.DEPTH(8), .ABITS(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .lut_we(lut_we), .lut_addr(lut_addr), .lut_din(lut_din),
      .busy(busy), .done(done), .err(err)
   );

   wvfm_loader #(.DEPTH(4096), .ABITS(12)) dut_big (
      .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
      .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .lut_we(b_we), .lut_addr(b_addr), .lut_din(b_din),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   typedef struct packed {
      logic [2:0]  a;
      logic [7:0]  d;
      logic [31:0] c;
   } wr_t;

   wr_t sb[$];
   wr_t e;
   int  total = 0;
   int  bad = 0;
   int  cyc = 0;
   int  done_cnt = 0;
   int  b_exp = 0;
   int  b_writes = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every LUT write must match the next expected entry,
   // including the cycle right after its acceptance.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
      if (lut_we === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL stray_write got addr=%0d data=%h want none",
                     lut_addr, lut_din);
         end else begin
            e = sb.pop_front();
            if (lut_addr !== e.a || lut_din !== e.d || cyc !== int'(e.c)) begin
               bad++;
               $display("FAIL lut_write got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                        lut_addr, lut_din, cyc, e.a, e.d, e.c);
            end
         end
      end
   end

   // Big instance: addresses must run 0..4095 in order, all 0xFF.
   always @(negedge clk) begin
      if (b_we === 1'b1) begin
         total++;
         if (int'(b_addr) !== b_exp || b_din !== 8'hFF) begin
            bad++;
            $display("FAIL big_write got a=%0d d=%h want a=%0d d=ff",
                     b_addr, b_din, b_exp);
         end
         b_exp++;
         b_writes++;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic pay,
                       input logic [2:0] a);
      s_data  = d;
      s_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_ready === 1'b1) begin
            if (pay) sb.push_back('{a: a, d: d, c: 32'(cyc + 1)});
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      total++;
      bad++;
      $display("FAIL send_timeout got ready=%b want 1", s_ready);
      s_valid = 1'b0;
   endtask

   task automatic load_payload(input logic [7:0] base);
      for (int i = 0; i < 8; i++) send(base + 8'(i), 1'b1, 3'(i));
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0;
      s_data = 8'h00;
      b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0;
      b_data = 8'h00;
      idle(3);
      total++;
      if ({s_ready, lut_we, busy, done, err} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags got %b want 00000",
                  {s_ready, lut_we, busy, done, err});
      end
      total++;
      if (lut_addr !== 3'd0 || lut_din !== 8'h00) begin
         bad++;
         $display("FAIL reset_lut got a=%0d d=%h want 0 00", lut_addr, lut_din);
      end
      total++;
      if ({b_ready, b_we, b_busy, b_done, b_err} !== 5'b0 || b_addr !== 12'd0) begin
         bad++;
         $display("FAIL reset_big got %b a=%0d want 0",
                  {b_ready, b_we, b_busy, b_done, b_err}, b_addr);
      end
      rst = 1'b0;
      b_rst = 1'b0;
      idle(1);
   endtask

   task automatic test_good_load();
      int dc;
      dc = done_cnt;
      pulse_start();
      total++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL good_start got busy=%b err=%b want 1 0", busy, err);
      end
      load_payload(8'h01);
      send(8'h24, 1'b0, 3'd0);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL good_done got d=%b b=%b e=%b want 1 0 0", done, busy, err);
      end
      idle(1);
      total++;
      if (done !== 1'b0 || sb.size() != 0 || done_cnt != dc + 1) begin
         bad++;
         $display("FAIL good_end got done=%b q=%0d pulses=%0d want 0 0 1",
                  done, sb.size(), done_cnt - dc);
      end
   endtask

   task automatic test_bad_checksum();
      int dc;
      dc = done_cnt;
      pulse_start();
      load_payload(8'h01);
      send(8'h25, 1'b0, 3'd0);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
         bad++;
         $display("FAIL bad_done got d=%b b=%b e=%b want 1 0 1", done, busy, err);
      end
      idle(5);
      total++;
      if (err !== 1'b1 || sb.size() != 0 || done_cnt != dc + 1) begin
         bad++;
         $display("FAIL bad_hold got err=%b q=%0d pulses=%0d want 1 0 1",
                  err, sb.size(), done_cnt - dc);
      end
      pulse_start();
      total++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL bad_clear got err=%b busy=%b want 0 1", err, busy);
      end
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
   endtask

   task automatic test_stall();
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send(8'h30 + 8'(i), 1'b1, 3'(i));
         idle(2);
         total++;
         if (s_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold got rdy=%b busy=%b want 1 1", s_ready, busy);
         end
      end
      send(8'h9C, 1'b0, 3'd0);
      total++;
      if (done !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL stall_done got d=%b e=%b want 1 0", done, err);
      end
      idle(1);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL stall_queue got %0d want 0", sb.size());
      end
   endtask

   task automatic test_abort();
      int dc;
      dc = done_cnt;
      pulse_start();
      for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b1, 3'(i));
      abort = 1'b1;
      s_valid = 1'b1;
      s_data = 8'hFF;
      @(negedge clk);
      total++;
      if (s_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort_ready got %b want 0", s_ready);
      end
      @(posedge clk);
      #1;
      abort = 1'b0;
      s_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         bad++;
         $display("FAIL abort_exit got busy=%b err=%b want 0 1", busy, err);
      end
      idle(4);
      total++;
      if (sb.size() != 0 || done_cnt != dc) begin
         bad++;
         $display("FAIL abort_after got q=%0d pulses=%0d want 0 0",
                  sb.size(), done_cnt - dc);
      end
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || err !== 1'b1) begin
         bad++;
         $display("FAIL abort_idle got busy=%b err=%b want 0 1", busy, err);
      end
      start = 1'b1;
      abort = 1'b1;
      idle(1);
      start = 1'b0;
      abort = 1'b0;
      total++;
      if (busy !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL start_abort got busy=%b err=%b want 1 0", busy, err);
      end
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
   endtask

   task automatic test_start_rst();
      pulse_start();
      send(8'h11, 1'b1, 3'd0);
      send(8'h22, 1'b1, 3'd1);
      pulse_start();
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL midstart_busy got %b want 1", busy);
      end
      send(8'h33, 1'b1, 3'd2);
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b1;
      s_valid = 1'b1;
      s_data = 8'h55;
      idle(1);
      total++;
      if ({s_ready, lut_we, busy, done, err} !== 5'b0 ||
          lut_addr !== 3'd0 || lut_din !== 8'h00) begin
         bad++;
         $display("FAIL midrst got %b a=%0d d=%h want 0",
                  {s_ready, lut_we, busy, done, err}, lut_addr, lut_din);
      end
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      s_valid = 1'b0;
      idle(1);
      pulse_start();
      load_payload(8'h10);
      send(8'h9C, 1'b0, 3'd0);
      total++;
      if (done !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL rst_reload got d=%b e=%b want 1 0", done, err);
      end
      idle(2);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL rst_queue got %0d want 0", sb.size());
      end
   endtask

   task automatic test_big();
      b_start = 1'b1;
      idle(1);
      b_start = 1'b0;
      b_data = 8'hFF;
      b_valid = 1'b1;
      idle(4096);
      b_data = 8'h00;
      idle(1);
      b_valid = 1'b0;
      total++;
      if (b_done !== 1'b1 || b_err !== 1'b0 || b_busy !== 1'b0) begin
         bad++;
         $display("FAIL big_done got d=%b e=%b b=%b want 1 0 0",
                  b_done, b_err, b_busy);
      end
      idle(3);
      total++;
      if (b_writes != 4096) begin
         bad++;
         $display("FAIL big_count got %0d want 4096", b_writes);
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_stall();
      test_abort();
      test_start_rst();
      test_big();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
